// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin write arbiter for a shared buffer write port
//
// Purpose:
//   Shares one buffer write port between NUM_REQ valid/ready producers.
//   Each cycle at most one beat moves from the granted producer to the buffer.
//   A full buffer back-pressures the granted producer.
//   Optional packet lock: when FIFO_ARB_PKT_LOCK_EN is defined, a requester keeps
//   the grant from its first beat until its req_last_i beat. This stops packets
//   from different requesters interleaving in the buffer. When the macro is
//   undefined, every beat is re-arbitrated.
//
// Ports:
//   clk_i        clock, all state on rising edge
//   rst_ni       asynchronous active-low reset
//   req_valid_i  per-requester beat valid
//   req_data_i   requester i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last_i   last beat of packet (lock feature only)
//   req_ready_o  beat i accepted this cycle when valid & ready
//   buf_wr_o     buffer write strobe
//   buf_wdata_o  buffer write data
//   buf_full_i   buffer full flag
//   grant_id_o   index of currently selected requester
//   locked_o     arbiter held in LOCK state

module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          buf_wr_o,
    output logic [DATA_WIDTH-1:0]         buf_wdata_o,
    input  logic                          buf_full_i,
    output logic [ID_WIDTH-1:0]           grant_id_o,
    output logic                          locked_o
);

    logic [ID_WIDTH-1:0] rr_ptr;
    logic [ID_WIDTH-1:0] rr_next;
    logic [ID_WIDTH-1:0] arb_id;
    logic [ID_WIDTH-1:0] cand;
    logic                arb_found;
    logic [ID_WIDTH-1:0] grant;
    logic                locked;
    logic                xfer;

    // Scan from rr_ptr upward, wrapping modulo NUM_REQ. With no valid
    // requester, the selection parks on rr_ptr.
    always_comb begin
        arb_id    = rr_ptr;
        arb_found = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_WIDTH'((int'(rr_ptr) + k) % NUM_REQ);
            if (!arb_found && req_valid_i[cand]) begin
                arb_found = 1'b1;
                arb_id    = cand;
            end
        end
    end

`ifdef FIFO_ARB_PKT_LOCK_EN
    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    logic [0:0]          state;
    logic [ID_WIDTH-1:0] lock_id;

    // A beat without last opens a packet and pins the grant. The pinned
    // requester's last beat closes it again.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= ST_ARB;
            lock_id <= '0;
        end else if (xfer) begin
            if (state == ST_ARB) begin
                if (!req_last_i[grant]) begin
                    state   <= ST_LOCK;
                    lock_id <= grant;
                end
            end else if (req_last_i[lock_id]) begin
                state <= ST_ARB;
            end
        end
    end

    assign locked = (state == ST_LOCK);
    assign grant  = locked ? lock_id : arb_id;
`else
    logic unused_last;
    assign unused_last = ^req_last_i;
    assign locked      = 1'b0;
    assign grant       = arb_id;
`endif

    assign xfer = req_valid_i[grant] & ~buf_full_i;

    always_comb begin
        req_ready_o        = '0;
        req_ready_o[grant] = xfer;
    end

    assign buf_wr_o    = xfer;
    assign buf_wdata_o = req_data_i[grant*DATA_WIDTH +: DATA_WIDTH];
    assign grant_id_o  = grant;
    assign locked_o    = locked;

    // Explicit wrap keeps the pointer in range for non-power-of-two NUM_REQ.
    assign rr_next = (grant == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant + ID_WIDTH'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr <= '0;
        end else if (xfer) begin
            rr_ptr <= rr_next;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;
`ifdef FIFO_ARB_PKT_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           buf_wr;
    logic [W-1:0]   buf_wdata;
    logic           buf_full;
    logic [IW-1:0]  grant_id;
    logic           locked;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_rr   = 0;
    bit m_lock = 1'b0;
    int m_lid  = 0;
    int last_grant;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .ID_WIDTH(IW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .buf_wr_o    (buf_wr),
        .buf_wdata_o (buf_wdata),
        .buf_full_i  (buf_full),
        .grant_id_o  (grant_id),
        .locked_o    (locked)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant(input logic [N-1:0] v);
        if (m_lock) return m_lid;
        for (int k = 0; k < N; k++)
            if (v[(m_rr + k) % N]) return (m_rr + k) % N;
        return m_rr;
    endfunction

    task automatic model_reset();
        m_rr   = 0;
        m_lock = 1'b0;
        m_lid  = 0;
    endtask

    // Drive one cycle of stimulus, check all outputs against the model, advance the model.
    task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] d,
                        input logic [N-1:0] l, input logic f);
        int           g;
        bit           x;
        logic [N-1:0] er;
        @(negedge clk);
        req_valid = v;
        req_data  = d;
        req_last  = l;
        buf_full  = f;
        #1;
        g  = model_grant(v);
        x  = v[g] && !f;
        er = '0;
        if (x) er[g] = 1'b1;
        check_eq("grant", grant_id, g);
        check_eq("ready", req_ready, er);
        check_eq("wr", buf_wr, x);
        if (x) check_eq("wdata", buf_wdata, d[g*W +: W]);
        check_eq("locked", locked, m_lock);
        last_grant = g;
        @(posedge clk);
        if (x) begin
            if (LOCK_EN) begin
                if (!m_lock && !l[g]) begin
                    m_lock = 1'b1;
                    m_lid  = g;
                end else if (m_lock && l[g]) begin
                    m_lock = 1'b0;
                end
            end
            m_rr = (g + 1) % N;
        end
    endtask

    initial begin
        int seq1[5];
        int seq5[4];
        int lck5[4];
        seq1 = '{0, 1, 2, 3, 0};
        if (LOCK_EN) begin
            seq5 = '{1, 1, 1, 0};
            lck5 = '{0, 1, 1, 0};
        end else begin
            seq5 = '{1, 0, 1, 0};
            lck5 = '{0, 0, 0, 0};
        end

        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        buf_full  = 1'b0;
        #12;
        check_eq("rst_ready", req_ready, 0);
        check_eq("rst_wr", buf_wr, 0);
        check_eq("rst_grant", grant_id, 0);
        check_eq("rst_locked", locked, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // All four valid: grants 0,1,2,3,0
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 32'h44332211, 4'b1111, 1'b0);
            check_eq("t1_seq", last_grant, seq1[i]);
        end

        // Only requester 2 valid
        step(4'b0100, 32'h00A50000, 4'b1111, 1'b0);
        check_eq("t2_grant", last_grant, 2);

        // Wrap from 3 to 0
        step(4'b1001, 32'h77000066, 4'b1111, 1'b0);
        check_eq("t3_g3", last_grant, 3);
        step(4'b1001, 32'h77000066, 4'b1111, 1'b0);
        check_eq("t3_g0", last_grant, 0);

        // Buffer full holds everything
        for (int i = 0; i < 5; i++) step(4'b0110, 32'h00BBCC00, 4'b1111, 1'b1);
        step(4'b0110, 32'h00BBCC00, 4'b1111, 1'b0);
        check_eq("t4_release", last_grant, 1);

        // Move pointer to 1
        step(4'b0001, 32'h000000EE, 4'b1111, 1'b0);

        // Packet of 3 beats from requester 1, requester 0 valid throughout
        for (int i = 0; i < 4; i++) begin
            step(4'b0011, {16'h0, 8'hB0 + 8'(i), 8'hA0 + 8'(i)},
                 {2'b00, (i >= 2) ? 1'b1 : 1'b0, 1'b1}, 1'b0);
            check_eq("t5_seq", last_grant, seq5[i]);
        end
        check_eq("t5_lock_trace", {28'h0, lck5[3], lck5[2], lck5[1], lck5[0]},
                 LOCK_EN ? 32'h6 : 32'h0);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            step(4'($urandom_range(0, 15)), $urandom,
                 4'(~($urandom & $urandom)), ($urandom_range(0, 3) == 0));
        end

        // Asynchronous reset mid-stream
        @(negedge clk);
        req_valid = 4'b1111;
        req_data  = 32'h44332211;
        req_last  = 4'b0000;
        buf_full  = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("arst_grant", grant_id, 0);
        check_eq("arst_locked", locked, 0);
        check_eq("arst_ready", req_ready, 4'b0001);
        req_valid = '0;
        #1;
        check_eq("arst_idle_ready", req_ready, 0);
        check_eq("arst_idle_wr", buf_wr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step(4'($urandom_range(0, 15)), $urandom,
                 4'(~($urandom & $urandom)), ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
